// File: rtl/prog_sequencer_if.sv
// Handshake and core-control bundle between the bench/top level and the
// program sequencer. master = requester/core side, slave = sequencer.
interface prog_sequencer_if #(
    parameter int PC_W = 10
);
    logic            req;
    logic            core_halt;
    logic            ack;
    logic            busy;
    logic            core_run;
    logic            pc_load;
    logic [PC_W-1:0] pc_start;
    logic [1:0]      prog_id;
    logic            timeout_err;

    modport master (
        output req,
        output core_halt,
        input  ack,
        input  busy,
        input  core_run,
        input  pc_load,
        input  pc_start,
        input  prog_id,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  core_halt,
        output ack,
        output busy,
        output core_run,
        output pc_load,
        output pc_start,
        output prog_id,
        output timeout_err
    );
endinterface

// File: rtl/prog_sequencer.sv
// Run controller: each request launches the next program in the rotation,
// loads its start PC, runs the core until halt or watchdog, then acks.
//
// state | meaning
// IDLE  | after reset, waiting for the first request
// LOAD  | one-cycle pc_load strobe, watchdog and error flag cleared
// RUN   | core enabled, watchdog counting, waiting for halt
// DONE  | ack held, next program selected, waiting for next request
module prog_sequencer #(
    parameter int PC_W     = 10,
    parameter int NUM_PROG = 3,
    parameter int START0   = 0,
    parameter int START1   = 128,
    parameter int START2   = 256,
    parameter int START3   = 384,
    parameter int TIMEOUT  = 65535,
    parameter int TO_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    prog_sequencer_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0]      LAST_PROG = 2'(NUM_PROG - 1);
    // Wraps to all-ones when TIMEOUT==0; the compare is masked in that case.
    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            req_q;
    logic            req_edge;
    logic [TO_W-1:0] wdog;
    logic            wdog_expire;
    logic [1:0]      prog_id;
    logic            timeout_err;
    logic [PC_W-1:0] pc_start;

    assign req_edge    = bus.req & ~req_q;
    assign wdog_expire = (TIMEOUT != 0) && (wdog == WDOG_LAST);

    // Next-state decode; requests outside IDLE/DONE are dropped, not queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_edge) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (bus.core_halt || wdog_expire) state_nxt = DONE;
            DONE:    if (req_edge) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and request edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req_q <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= bus.req;
        end
    end

    // Watchdog counts RUN cycles since the last LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog <= '0;
        end else if (state == LOAD) begin
            wdog <= '0;
        end else if (state == RUN) begin
            wdog <= wdog + 1'b1;
        end
    end

    // Advance the program rotation as the run finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_id <= 2'd0;
        end else if (state == RUN && state_nxt == DONE) begin
            prog_id <= (prog_id == LAST_PROG) ? 2'd0 : prog_id + 2'd1;
        end
    end

    // Error flag is sticky until the next LOAD; halt beats a same-cycle expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (state == LOAD) begin
            timeout_err <= 1'b0;
        end else if (state == RUN && !bus.core_halt && wdog_expire) begin
            timeout_err <= 1'b1;
        end
    end

    // Start address lookup, valid in every state.
    always_comb begin
        case (prog_id)
            2'd0:    pc_start = PC_W'(START0);
            2'd1:    pc_start = PC_W'(START1);
            2'd2:    pc_start = PC_W'(START2);
            default: pc_start = PC_W'(START3);
        endcase
    end

    assign bus.ack         = (state == DONE);
    assign bus.busy        = (state == LOAD) || (state == RUN);
    assign bus.core_run    = (state == RUN);
    assign bus.pc_load     = (state == LOAD);
    assign bus.pc_start    = pc_start;
    assign bus.prog_id     = prog_id;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: two instances share the same stimulus, one with
// the default watchdog and one with TIMEOUT=8, checked every cycle against a
// round-level model of where each run should be.
module tb_prog_sequencer;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;
    localparam int TO_B   = 8;

    logic clk = 1'b0;
    logic reset;
    logic req;
    logic core_halt;

    int vectors     = 0;
    int miscompares = 0;

    int start_tab [4] = '{0, 128, 256, 384};
    int prog_k   = 0;
    bit prev_a   = 1'b0;
    bit prev_b   = 1'b0;
    bit started  = 1'b0;

    prog_sequencer_if #(.PC_W(10)) ifa ();
    prog_sequencer_if #(.PC_W(10)) ifb ();

    assign ifa.req       = req;
    assign ifa.core_halt = core_halt;
    assign ifb.req       = req;
    assign ifb.core_halt = core_halt;

    prog_sequencer dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    prog_sequencer #(.TIMEOUT(TO_B), .TO_W(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string nm, input int ph, input int cur, input int nxt,
                              input bit perr, input bit err,
                              input logic a_ack, input logic a_busy, input logic a_run,
                              input logic a_load, input logic [9:0] a_pc,
                              input logic [1:0] a_prog, input logic a_err);
        int  prog;
        bit  terr;
        prog = (ph == P_DONE) ? nxt : cur;
        terr = (ph == P_LOAD) ? perr : (ph == P_DONE) ? err : 1'b0;
        chk({nm, ".ack"},         32'(a_ack),  32'(ph == P_DONE));
        chk({nm, ".busy"},        32'(a_busy), 32'(ph == P_LOAD || ph == P_RUN));
        chk({nm, ".core_run"},    32'(a_run),  32'(ph == P_RUN));
        chk({nm, ".pc_load"},     32'(a_load), 32'(ph == P_LOAD));
        chk({nm, ".prog_id"},     32'(a_prog), 32'(prog));
        chk({nm, ".pc_start"},    32'(a_pc),   32'(start_tab[prog]));
        chk({nm, ".timeout_err"}, 32'(a_err),  32'(terr));
    endtask

    task automatic check_both(input int ph_a, input int ph_b, input int cur, input int nxt,
                              input bit ea, input bit eb);
        check_inst("a", ph_a, cur, nxt, prev_a, ea, ifa.ack, ifa.busy, ifa.core_run,
                   ifa.pc_load, ifa.pc_start, ifa.prog_id, ifa.timeout_err);
        check_inst("b", ph_b, cur, nxt, prev_b, eb, ifb.ack, ifb.busy, ifb.core_run,
                   ifb.pc_load, ifb.pc_start, ifb.prog_id, ifb.timeout_err);
    endtask

    // Quiet cycles between runs: ack must hold, stray halts are ignored.
    task automatic idle(input int n);
        int ph;
        ph = started ? P_DONE : P_IDLE;
        for (int i = 0; i < n; i++) begin
            core_halt = 1'($urandom_range(0, 1));
            tick();
            check_both(ph, ph, prog_k, prog_k, prev_a, prev_b);
        end
        core_halt = 1'b0;
    endtask

    function automatic int phase_of(input int j, input int run_len);
        if (j == 1) return P_LOAD;
        if (j <= run_len + 1) return P_RUN;
        return P_DONE;
    endfunction

    // One launch: halt after d RUN cycles, req held h cycles, optional
    // extra req pulse in cycle p (0 = none). Cycle 1 is LOAD.
    task automatic run_round(input int d, input int h, input int p);
        int rl_a, rl_b, nxt, last, loads_a, loads_b;
        bit ea, eb;
        rl_a = d;
        ea   = 1'b0;
        rl_b = (d > TO_B) ? TO_B : d;
        eb   = (d > TO_B);
        nxt  = (prog_k == 2) ? 0 : prog_k + 1;
        last = d + 2;
        if (h + 1 > last) last = h + 1;
        if (p + 1 > last) last = p + 1;
        loads_a = 0;
        loads_b = 0;
        req = 1'b1;
        core_halt = 1'b0;
        for (int j = 1; j <= last; j++) begin
            tick();
            check_both(phase_of(j, rl_a), phase_of(j, rl_b), prog_k, nxt, ea, eb);
            loads_a += int'(ifa.pc_load);
            loads_b += int'(ifb.pc_load);
            req       = (j < h) || (j == p);
            core_halt = (j == d + 1);
        end
        req = 1'b0;
        core_halt = 1'b0;
        chk("a.pc_load_count", 32'(loads_a), 32'd1);
        chk("b.pc_load_count", 32'(loads_b), 32'd1);
        prog_k  = nxt;
        prev_a  = ea;
        prev_b  = eb;
        started = 1'b1;
        idle(2);
    endtask

    initial begin
        int d, h, p, minr;
        req = 1'b0;
        core_halt = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();
        check_both(P_IDLE, P_IDLE, 0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        idle(2);

        // Long run: instance b times out after 8 RUN cycles, a halts at 40.
        run_round(40, 1, 0);
        idle(20);
        // Rotation with held req and a spurious pulse mid-run.
        run_round(5, 1, 3);
        run_round(8, 10, 0);
        run_round(9, 1, 2);
        run_round(1, 10, 0);

        for (int r = 0; r < 20; r++) begin
            d = $urandom_range(1, 30);
            h = $urandom_range(1, 10);
            minr = (d < TO_B) ? d : TO_B;
            p = 0;
            if ($urandom_range(0, 1) == 1 && h + 1 <= minr + 1)
                p = $urandom_range(h + 1, minr + 1);
            run_round(d, h, p);
        end

        // Reset in the middle of a run.
        if (prog_k == 0) run_round(3, 1, 0);
        req = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            check_both(phase_of(j, 100), phase_of(j, 100), prog_k, prog_k, 1'b0, 1'b0);
            req = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        prog_k  = 0;
        prev_a  = 1'b0;
        prev_b  = 1'b0;
        started = 1'b0;
        check_both(P_IDLE, P_IDLE, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        idle(2);
        run_round(12, 2, 0);
        run_round(4, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
